// File: rtl/wasm_mem_access_unit_pkg.sv
// rtl/wasm_mem_access_unit_pkg.sv - shared types and helpers for the wasm memory access front-end
package wasm_mem_access_unit_pkg;

  localparam int unsigned MEMORY_PAGES = 16;
  localparam logic [31:0] GROW_FAIL    = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    MEM_OP_NONE,
    MEM_LOAD_I32,
    MEM_LOAD_I64,
    MEM_LOAD_8S,
    MEM_LOAD_8U,
    MEM_LOAD_16S,
    MEM_LOAD_16U,
    MEM_STORE_I32,
    MEM_STORE_I64,
    MEM_STORE_I8,
    MEM_STORE_I16
  } mem_op_t;

  typedef enum logic [1:0] {
    TRAP_NONE,
    TRAP_OUT_OF_BOUNDS,
    TRAP_UNREACHABLE,
    TRAP_DIV_ZERO
  } trap_t;

  typedef enum logic [1:0] {
    MREQ_LOAD,
    MREQ_STORE,
    MREQ_SIZE,
    MREQ_GROW
  } mem_req_kind_t;

  typedef enum logic [1:0] {
    MACC_IDLE,
    MACC_ACCESS,
    MACC_WAIT,
    MACC_RESP
  } mem_acc_state_t;

  function automatic logic is_load_op(mem_op_t op);
    return op inside {MEM_LOAD_I32, MEM_LOAD_I64, MEM_LOAD_8S, MEM_LOAD_8U,
                      MEM_LOAD_16S, MEM_LOAD_16U};
  endfunction

  function automatic logic is_store_op(mem_op_t op);
    return op inside {MEM_STORE_I32, MEM_STORE_I64, MEM_STORE_I8, MEM_STORE_I16};
  endfunction

endpackage

// File: rtl/wasm_mem_access_unit.sv
// rtl/wasm_mem_access_unit.sv - single-outstanding load/store/size/grow sequencer in front of linear memory
module wasm_mem_access_unit
  import wasm_mem_access_unit_pkg::*;
#(
  parameter int unsigned MAX_PAGES = MEMORY_PAGES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  mem_req_kind_t req_kind,
  input  mem_op_t       req_op,
  input  logic [31:0]   req_base,
  input  logic [31:0]   req_offset,
  input  logic [63:0]   req_wdata,
  input  logic [31:0]   req_grow_pages,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [63:0]   rsp_data,
  output trap_t         rsp_trap,
  output logic          mem_rd_en,
  output logic [31:0]   mem_rd_addr,
  output mem_op_t       mem_rd_op,
  input  logic [63:0]   mem_rd_data,
  input  logic          mem_rd_valid,
  output logic          mem_wr_en,
  output logic [31:0]   mem_wr_addr,
  output mem_op_t       mem_wr_op,
  output logic [63:0]   mem_wr_data,
  input  logic          mem_wr_valid,
  output logic          mem_grow_en,
  output logic [31:0]   mem_grow_pages,
  input  logic [31:0]   mem_current_pages,
  input  logic [31:0]   mem_grow_result,
  input  trap_t         mem_trap
);

  localparam logic [31:0] MAX_PAGES_W = 32'(MAX_PAGES);

  mem_acc_state_t state;
  mem_req_kind_t  lat_kind;
  mem_op_t        lat_op;
  logic [31:0]    lat_addr;
  logic [63:0]    lat_wdata;
  logic [31:0]    lat_grow_pages;
  logic [32:0]    ea33;

  // Carry out of bit 31 means the wasm effective address left the 4 GiB space.
  assign ea33 = {1'b0, req_base} + {1'b0, req_offset};

  assign req_ready      = (state == MACC_IDLE);
  assign rsp_valid      = (state == MACC_RESP);
  assign mem_rd_addr    = lat_addr;
  assign mem_rd_op      = lat_op;
  assign mem_wr_addr    = lat_addr;
  assign mem_wr_op      = lat_op;
  assign mem_wr_data    = lat_wdata;
  assign mem_grow_pages = lat_grow_pages;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= MACC_IDLE;
      lat_kind       <= MREQ_LOAD;
      lat_op         <= MEM_OP_NONE;
      lat_addr       <= '0;
      lat_wdata      <= '0;
      lat_grow_pages <= '0;
      rsp_data       <= '0;
      rsp_trap       <= TRAP_NONE;
      mem_rd_en      <= 1'b0;
      mem_wr_en      <= 1'b0;
      mem_grow_en    <= 1'b0;
    end else begin
      case (state)
        MACC_IDLE: begin
          if (req_valid) begin
            lat_kind       <= req_kind;
            lat_op         <= req_op;
            lat_addr       <= ea33[31:0];
            lat_wdata      <= req_wdata;
            lat_grow_pages <= req_grow_pages;
            rsp_data       <= '0;
            rsp_trap       <= TRAP_NONE;
            case (req_kind)
              MREQ_LOAD, MREQ_STORE: begin
                if (ea33[32]) begin
                  rsp_trap <= TRAP_OUT_OF_BOUNDS;
                  state    <= MACC_RESP;
                end else begin
                  mem_rd_en <= (req_kind == MREQ_LOAD);
                  mem_wr_en <= (req_kind == MREQ_STORE);
                  state     <= MACC_ACCESS;
                end
              end
              MREQ_SIZE: begin
                rsp_data <= {32'b0, mem_current_pages};
                state    <= MACC_RESP;
              end
              default: begin
                // Oversized deltas are refused here so memory never sees a wrapping page sum.
                if (req_grow_pages > MAX_PAGES_W) begin
                  rsp_data <= {32'b0, GROW_FAIL};
                  state    <= MACC_RESP;
                end else begin
                  mem_grow_en <= 1'b1;
                  state       <= MACC_ACCESS;
                end
              end
            endcase
          end
        end
        MACC_ACCESS: begin
          mem_rd_en   <= 1'b0;
          mem_wr_en   <= 1'b0;
          mem_grow_en <= 1'b0;
          case (lat_kind)
            MREQ_LOAD: begin
              rsp_trap <= mem_trap;
              rsp_data <= (mem_trap == TRAP_NONE && mem_rd_valid) ? mem_rd_data : '0;
              state    <= MACC_RESP;
            end
            MREQ_STORE: begin
              rsp_trap <= mem_trap;
              state    <= (mem_trap != TRAP_NONE) ? MACC_RESP : MACC_WAIT;
            end
            MREQ_GROW: state <= MACC_WAIT;
            default:   state <= MACC_RESP;
          endcase
        end
        MACC_WAIT: begin
          if (lat_kind == MREQ_STORE) begin
            rsp_trap <= mem_wr_valid ? TRAP_NONE : TRAP_OUT_OF_BOUNDS;
          end else if (lat_kind == MREQ_GROW) begin
            rsp_data <= {32'b0, mem_grow_result};
          end
          state <= MACC_RESP;
        end
        default: begin
          if (rsp_ready) state <= MACC_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wasm_mem_access_unit.sv
// tb/tb_wasm_mem_access_unit.sv - scoreboard bench for wasm_mem_access_unit with a behavioural linear memory
module tb_wasm_mem_access_unit;
  import wasm_mem_access_unit_pkg::*;

  localparam int MDL_PAGES = 4;
  localparam int MDL_BYTES = MDL_PAGES * 65536;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  mem_req_kind_t req_kind;
  mem_op_t       req_op;
  logic [31:0]   req_base;
  logic [31:0]   req_offset;
  logic [63:0]   req_wdata;
  logic [31:0]   req_grow_pages;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [63:0]   rsp_data;
  trap_t         rsp_trap;
  logic          mem_rd_en;
  logic [31:0]   mem_rd_addr;
  mem_op_t       mem_rd_op;
  logic [63:0]   mem_rd_data;
  logic          mem_rd_valid;
  logic          mem_wr_en;
  logic [31:0]   mem_wr_addr;
  mem_op_t       mem_wr_op;
  logic [63:0]   mem_wr_data;
  logic          mem_wr_valid;
  logic          mem_grow_en;
  logic [31:0]   mem_grow_pages;
  logic [31:0]   mem_current_pages;
  logic [31:0]   mem_grow_result;
  trap_t         mem_trap;

  always #5 clk = ~clk;

  wasm_mem_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_kind          (req_kind),
    .req_op            (req_op),
    .req_base          (req_base),
    .req_offset        (req_offset),
    .req_wdata         (req_wdata),
    .req_grow_pages    (req_grow_pages),
    .rsp_valid         (rsp_valid),
    .rsp_ready         (rsp_ready),
    .rsp_data          (rsp_data),
    .rsp_trap          (rsp_trap),
    .mem_rd_en         (mem_rd_en),
    .mem_rd_addr       (mem_rd_addr),
    .mem_rd_op         (mem_rd_op),
    .mem_rd_data       (mem_rd_data),
    .mem_rd_valid      (mem_rd_valid),
    .mem_wr_en         (mem_wr_en),
    .mem_wr_addr       (mem_wr_addr),
    .mem_wr_op         (mem_wr_op),
    .mem_wr_data       (mem_wr_data),
    .mem_wr_valid      (mem_wr_valid),
    .mem_grow_en       (mem_grow_en),
    .mem_grow_pages    (mem_grow_pages),
    .mem_current_pages (mem_current_pages),
    .mem_grow_result   (mem_grow_result),
    .mem_trap          (mem_trap)
  );

  // Behavioural linear memory: combinational reads/traps, registered write ack and grow result.
  logic [7:0]  mdl_mem [0:MDL_BYTES-1];
  logic [31:0] cur_pages;
  logic [63:0] mdl_raw;
  bit          mdl_init_done = 1'b0;
  int          rd_en_cnt = 0;
  int          wr_en_cnt = 0;
  int          grow_en_cnt = 0;

  assign mem_current_pages = cur_pages;

  function automatic int op_bytes(mem_op_t op);
    case (op)
      MEM_LOAD_I64, MEM_STORE_I64:                return 8;
      MEM_LOAD_I32, MEM_STORE_I32:                return 4;
      MEM_LOAD_16S, MEM_LOAD_16U, MEM_STORE_I16:  return 2;
      default:                                    return 1;
    endcase
  endfunction

  function automatic bit oob(logic [31:0] addr, mem_op_t op, logic [31:0] pages);
    return (64'(addr) + 64'(op_bytes(op))) > (64'(pages) * 64'd65536);
  endfunction

  always_comb begin
    mdl_raw      = '0;
    mem_rd_data  = '0;
    mem_rd_valid = 1'b0;
    mem_trap     = TRAP_NONE;
    if (mem_rd_en && is_load_op(mem_rd_op)) begin
      if (oob(mem_rd_addr, mem_rd_op, cur_pages)) begin
        mem_trap = TRAP_OUT_OF_BOUNDS;
      end else begin
        for (int i = 0; i < 8; i++)
          if (i < op_bytes(mem_rd_op)) mdl_raw[8*i +: 8] = mdl_mem[18'(mem_rd_addr + 32'(i))];
        case (mem_rd_op)
          MEM_LOAD_I32: mem_rd_data = {32'b0, mdl_raw[31:0]};
          MEM_LOAD_8S:  mem_rd_data = {{56{mdl_raw[7]}}, mdl_raw[7:0]};
          MEM_LOAD_16S: mem_rd_data = {{48{mdl_raw[15]}}, mdl_raw[15:0]};
          default:      mem_rd_data = mdl_raw;
        endcase
        mem_rd_valid = 1'b1;
      end
    end
    if (mem_wr_en && is_store_op(mem_wr_op) && oob(mem_wr_addr, mem_wr_op, cur_pages))
      mem_trap = TRAP_OUT_OF_BOUNDS;
  end

  always @(posedge clk) begin
    if (!mdl_init_done) begin
      for (int i = 0; i < MDL_BYTES; i++) mdl_mem[i] <= 8'h00;
      mdl_mem[16]     <= 8'h44;
      mdl_mem[17]     <= 8'h33;
      mdl_mem[18]     <= 8'h22;
      mdl_mem[19]     <= 8'h11;
      cur_pages       <= 32'd1;
      mem_wr_valid    <= 1'b0;
      mem_grow_result <= '0;
      mdl_init_done   <= 1'b1;
    end else begin
      mem_wr_valid <= 1'b0;
      if (mem_rd_en)   rd_en_cnt   <= rd_en_cnt + 1;
      if (mem_wr_en)   wr_en_cnt   <= wr_en_cnt + 1;
      if (mem_grow_en) grow_en_cnt <= grow_en_cnt + 1;
      if (mem_wr_en && is_store_op(mem_wr_op) && !oob(mem_wr_addr, mem_wr_op, cur_pages)) begin
        for (int i = 0; i < 8; i++)
          if (i < op_bytes(mem_wr_op)) mdl_mem[18'(mem_wr_addr + 32'(i))] <= mem_wr_data[8*i +: 8];
        mem_wr_valid <= 1'b1;
      end
      if (mem_grow_en) begin
        if (64'(cur_pages) + 64'(mem_grow_pages) <= 64'(MDL_PAGES)) begin
          mem_grow_result <= cur_pages;
          cur_pages       <= cur_pages + mem_grow_pages;
        end else begin
          mem_grow_result <= GROW_FAIL;
        end
      end
    end
  end

  typedef struct {
    mem_req_kind_t kind;
    mem_op_t       op;
    logic [31:0]   base;
    logic [31:0]   off;
    logic [63:0]   wdata;
    logic [31:0]   pages;
    logic [63:0]   exp_data;
    trap_t         exp_trap;
    int            exp_lat;
    string         name;
  } req_t;

  typedef struct {
    logic [63:0] data;
    trap_t       trap;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Drives one request, pushes its expectation, and returns what the DUT answered and how late.
  task automatic do_req(input req_t r, output logic [63:0] d, output trap_t t, output int lat);
    int guard;
    exp_q.push_back('{r.exp_data, r.exp_trap, r.exp_lat});
    @(negedge clk);
    req_kind       = r.kind;
    req_op         = r.op;
    req_base       = r.base;
    req_offset     = r.off;
    req_wdata      = r.wdata;
    req_grow_pages = r.pages;
    req_valid      = 1'b1;
    rsp_ready      = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    d = rsp_data;
    t = rsp_trap;
    @(posedge clk);
  endtask

  task automatic test_reset();
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_req_ready: got %b, expected 1", req_ready);
    end
    n_tests++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_rsp_valid: got %b, expected 0", rsp_valid);
    end
    n_tests++;
    if (rsp_data !== 64'h0) begin
      n_fail++; $display("FAIL reset_rsp_data: got %h, expected 0", rsp_data);
    end
    n_tests++;
    if (rsp_trap !== TRAP_NONE) begin
      n_fail++; $display("FAIL reset_rsp_trap: got %0d, expected %0d", rsp_trap, TRAP_NONE);
    end
    n_tests++;
    if ({mem_rd_en, mem_wr_en, mem_grow_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mem_en: got %b, expected 000", {mem_rd_en, mem_wr_en, mem_grow_en});
    end
  endtask

  task automatic test_load_store();
    req_t        tbl[$];
    exp_t        e;
    logic [63:0] d;
    trap_t       t;
    int          lat, rd0, wr0;
    tbl.push_back('{MREQ_LOAD,  MEM_LOAD_I32,  32'h8,         32'h8,  64'h0,    32'h0, 64'h11223344, TRAP_NONE,          2, "ld_i32"});
    tbl.push_back('{MREQ_LOAD,  MEM_LOAD_I32,  32'hFFFFFFF0,  32'h20, 64'h0,    32'h0, 64'h0,        TRAP_OUT_OF_BOUNDS, 1, "ld_ea_ovf"});
    tbl.push_back('{MREQ_LOAD,  MEM_LOAD_I32,  32'hFFFFFFF0,  32'hF,  64'h0,    32'h0, 64'h0,        TRAP_OUT_OF_BOUNDS, 2, "ld_ea_max"});
    tbl.push_back('{MREQ_STORE, MEM_STORE_I16, 32'hFFFE,      32'h0,  64'hBEEF, 32'h0, 64'h0,        TRAP_NONE,          3, "st_i16"});
    tbl.push_back('{MREQ_LOAD,  MEM_LOAD_16U,  32'hFFFE,      32'h0,  64'h0,    32'h0, 64'hBEEF,     TRAP_NONE,          2, "ld_16u"});
    tbl.push_back('{MREQ_STORE, MEM_STORE_I16, 32'hFFFF,      32'h0,  64'h1234, 32'h0, 64'h0,        TRAP_OUT_OF_BOUNDS, 2, "st_i16_oob"});
    tbl.push_back('{MREQ_LOAD,  MEM_LOAD_8U,   32'hFFFF,      32'h0,  64'h0,    32'h0, 64'hBE,       TRAP_NONE,          2, "ld_8u_kept"});
    tbl.push_back('{MREQ_STORE, MEM_STORE_I32, 32'hFFFFFFFF,  32'h1,  64'h55,   32'h0, 64'h0,        TRAP_OUT_OF_BOUNDS, 1, "st_ea_ovf"});
    tbl.push_back('{MREQ_LOAD,  MEM_STORE_I32, 32'h10,        32'h0,  64'h0,    32'h0, 64'h0,        TRAP_NONE,          2, "ld_bad_op"});
    rd0 = rd_en_cnt;
    wr0 = wr_en_cnt;
    foreach (tbl[i]) begin
      do_req(tbl[i], d, t, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e.data || t !== e.trap) begin
        n_fail++;
        $display("FAIL %s rsp: got data=%h trap=%0d, expected data=%h trap=%0d", tbl[i].name, d, t, e.data, e.trap);
      end
      n_tests++;
      if (lat != e.lat) begin
        n_fail++; $display("FAIL %s latency: got %0d, expected %0d", tbl[i].name, lat, e.lat);
      end
    end
    n_tests++;
    if (rd_en_cnt - rd0 != 5 || wr_en_cnt - wr0 != 2) begin
      n_fail++;
      $display("FAIL ls_mem_en_count: got rd=%0d wr=%0d, expected rd=5 wr=2", rd_en_cnt - rd0, wr_en_cnt - wr0);
    end
  endtask

  task automatic test_grow_size();
    req_t        tbl[$];
    exp_t        e;
    logic [63:0] d;
    trap_t       t;
    int          lat, g0;
    tbl.push_back('{MREQ_SIZE, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'h0,         64'd1,          TRAP_NONE, 1, "size_1"});
    tbl.push_back('{MREQ_GROW, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'd2,         64'd1,          TRAP_NONE, 3, "grow_2"});
    tbl.push_back('{MREQ_SIZE, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'h0,         64'd3,          TRAP_NONE, 1, "size_3"});
    tbl.push_back('{MREQ_GROW, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'd0,         64'd3,          TRAP_NONE, 3, "grow_0"});
    tbl.push_back('{MREQ_GROW, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'd16,        64'hFFFFFFFF,   TRAP_NONE, 3, "grow_max_mem_fail"});
    tbl.push_back('{MREQ_GROW, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'd17,        64'hFFFFFFFF,   TRAP_NONE, 1, "grow_over_max"});
    tbl.push_back('{MREQ_GROW, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'hFFFFFFFF,  64'hFFFFFFFF,   TRAP_NONE, 1, "grow_all_ones"});
    g0 = grow_en_cnt;
    foreach (tbl[i]) begin
      do_req(tbl[i], d, t, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e.data || t !== e.trap) begin
        n_fail++;
        $display("FAIL %s rsp: got data=%h trap=%0d, expected data=%h trap=%0d", tbl[i].name, d, t, e.data, e.trap);
      end
      n_tests++;
      if (lat != e.lat) begin
        n_fail++; $display("FAIL %s latency: got %0d, expected %0d", tbl[i].name, lat, e.lat);
      end
    end
    n_tests++;
    if (grow_en_cnt - g0 != 3) begin
      n_fail++; $display("FAIL grow_en_count: got %0d, expected 3", grow_en_cnt - g0);
    end
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [63:0] d0;
    int          guard, rd0, wr0, g0;
    rd0 = rd_en_cnt; wr0 = wr_en_cnt; g0 = grow_en_cnt;
    exp_q.push_back('{64'h11223344, TRAP_NONE, 2});
    @(negedge clk);
    req_kind = MREQ_LOAD; req_op = MEM_LOAD_I32; req_base = 32'h10; req_offset = 32'h0;
    req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk);
    #1 req_kind = MREQ_SIZE;
    guard = 0;
    @(negedge clk);
    while (!rsp_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    e = exp_q.pop_front();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_trap !== e.trap) begin
      n_fail++;
      $display("FAIL bp_rsp: got valid=%b data=%h trap=%0d, expected valid=1 data=%h trap=%0d", rsp_valid, rsp_data, rsp_trap, e.data, e.trap);
    end
    d0 = e.data;
    repeat (5) begin
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== d0) begin
        n_fail++;
        $display("FAIL bp_hold: got valid=%b ready=%b data=%h, expected valid=1 ready=0 data=%h", rsp_valid, req_ready, rsp_data, d0);
      end
    end
    n_tests++;
    if (rd_en_cnt - rd0 != 1 || wr_en_cnt != wr0 || grow_en_cnt != g0) begin
      n_fail++;
      $display("FAIL bp_mem_en: got rd=%0d wr=%0d grow=%0d, expected rd=1 wr=0 grow=0", rd_en_cnt - rd0, wr_en_cnt - wr0, grow_en_cnt - g0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: got ready=%b valid=%b, expected ready=1 valid=0", req_ready, rsp_valid);
    end
    exp_q.push_back('{64'd3, TRAP_NONE, 1});
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    n_tests++;
    if (rsp_valid !== 1'b1 || rsp_data !== e.data || rsp_trap !== e.trap) begin
      n_fail++;
      $display("FAIL bp_next_req: got valid=%b data=%h trap=%0d, expected valid=1 data=%h trap=%0d", rsp_valid, rsp_data, rsp_trap, e.data, e.trap);
    end
    @(posedge clk);
  endtask

  task automatic test_reset_mid_op();
    req_t        r;
    exp_t        e;
    logic [63:0] d;
    trap_t       t;
    int          lat;
    bit          bad;
    @(negedge clk);
    req_kind = MREQ_GROW; req_op = MEM_OP_NONE; req_grow_pages = 32'd1;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 64'h0 || rsp_trap !== TRAP_NONE ||
        {mem_rd_en, mem_wr_en, mem_grow_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL midop_reset_outputs: got ready=%b valid=%b data=%h trap=%0d en=%b, expected 1 0 0 0 000",
               req_ready, rsp_valid, rsp_data, rsp_trap, {mem_rd_en, mem_wr_en, mem_grow_en});
    end
    rst = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++; $display("FAIL midop_no_rsp: got valid=%b ready=%b, expected valid=0 ready=1 throughout", rsp_valid, req_ready);
    end
    r = '{MREQ_SIZE, MEM_OP_NONE, 32'h0, 32'h0, 64'h0, 32'h0, 64'd4, TRAP_NONE, 1, "midop_size"};
    do_req(r, d, t, lat);
    e = exp_q.pop_front();
    n_tests++;
    if (d !== e.data || t !== e.trap || lat != e.lat) begin
      n_fail++;
      $display("FAIL midop_size: got data=%h trap=%0d lat=%0d, expected data=%h trap=%0d lat=%0d", d, t, lat, e.data, e.trap, e.lat);
    end
  endtask

  task automatic test_back_to_back();
    req_t        tbl[$];
    exp_t        e;
    logic [63:0] d;
    trap_t       t;
    logic [31:0] w [4];
    logic [63:0] w64;
    int          lat;
    for (int i = 0; i < 4; i++) begin
      w[i] = $urandom;
      tbl.push_back('{MREQ_STORE, MEM_STORE_I32, 32'h100, 32'(8*i), 64'(w[i]), 32'h0, 64'h0, TRAP_NONE, 3, "b2b_st32"});
    end
    w64 = {$urandom, $urandom};
    tbl.push_back('{MREQ_STORE, MEM_STORE_I64, 32'h200, 32'h0, w64, 32'h0, 64'h0, TRAP_NONE, 3, "b2b_st64"});
    for (int i = 0; i < 4; i++)
      tbl.push_back('{MREQ_LOAD, MEM_LOAD_I32, 32'h100, 32'(8*i), 64'h0, 32'h0, {32'b0, w[i]}, TRAP_NONE, 2, "b2b_ld32"});
    tbl.push_back('{MREQ_LOAD, MEM_LOAD_I64, 32'h1F8, 32'h8, 64'h0, 32'h0, w64, TRAP_NONE, 2, "b2b_ld64"});
    foreach (tbl[i]) begin
      do_req(tbl[i], d, t, lat);
      e = exp_q.pop_front();
      n_tests++;
      if (d !== e.data || t !== e.trap || lat != e.lat) begin
        n_fail++;
        $display("FAIL %s[%0d]: got data=%h trap=%0d lat=%0d, expected data=%h trap=%0d lat=%0d",
                 tbl[i].name, i, d, t, lat, e.data, e.trap, e.lat);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_kind = MREQ_LOAD;
    req_op = MEM_OP_NONE;
    req_base = '0;
    req_offset = '0;
    req_wdata = '0;
    req_grow_pages = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_load_store();
    test_grow_size();
    test_backpressure();
    test_reset_mid_op();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
